// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared types, default sizes and arithmetic helpers for the CIM LIF macro
// Contents: controller state enum, default parameter values, config-word layout
// helpers, membrane saturation and leak functions.
package cim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INT  = 2'd1,
        ST_FIRE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_N_NEURON = 16;
    localparam int DEF_N_INPUT  = 256;
    localparam int DEF_CHUNK    = 32;
    localparam int DEF_W_WIDTH  = 2;
    localparam int DEF_V_WIDTH  = 8;
    localparam int DEF_LEAK_W   = 4;
    localparam int DEF_REF_W    = 3;

    // Per-neuron config word: {enb, refr, leak, vth}, vth in the low bits.
    function automatic int cfg_width(input int vw, input int lw, input int rw);
        return vw + lw + rw + 1;
    endfunction

    function automatic int num_chunks(input int ni, input int ch);
        return ni / ch;
    endfunction

    function automatic int leak_lsb(input int vw);
        return vw;
    endfunction

    function automatic int refr_lsb(input int vw, input int lw);
        return vw + lw;
    endfunction

    function automatic int enb_bit(input int vw, input int lw, input int rw);
        return vw + lw + rw;
    endfunction

    // Clamp to the signed range of a vw-bit membrane.
    function automatic int sat_v(input int x, input int vw);
        int hi;
        int lo;
        int r;
        hi = (1 << (vw - 1)) - 1;
        lo = -(1 << (vw - 1));
        r  = x;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end
        return r;
    endfunction

    // Move t toward zero by l without crossing zero.
    function automatic int leak(input int t, input int l);
        int r;
        r = 0;
        if (t > 0) begin
            r = (t > l) ? (t - l) : 0;
        end else if (t < 0) begin
            r = (-t > l) ? (t + l) : 0;
        end
        return r;
    endfunction

endpackage

// File: rtl/cim_lif_neuron.sv
// rtl/cim_lif_neuron.sv - one leaky integrate-and-fire neuron with accumulator and refractory counter
// Ports: clk/rst_n; clr_all (power-down wipe), clr_state (first-timestep wipe of v/refr),
// integrate (add one chunk), fire_en (fire evaluation); swp/rst_sub modes; spikes/weights
// for the current chunk; enb/refr_cfg/leak_cfg/vth config; fire (combinational decision),
// v (membrane).
module cim_lif_neuron
    import cim_pkg::*;
#(
    parameter int CHUNK   = DEF_CHUNK,
    parameter int W_WIDTH = DEF_W_WIDTH,
    parameter int V_WIDTH = DEF_V_WIDTH,
    parameter int LEAK_W  = DEF_LEAK_W,
    parameter int REF_W   = DEF_REF_W,
    parameter int ACC_W   = 18
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_all,
    input  logic                        clr_state,
    input  logic                        integrate,
    input  logic                        fire_en,
    input  logic                        swp,
    input  logic                        rst_sub,
    input  logic [CHUNK-1:0]            spikes,
    input  logic [CHUNK*W_WIDTH-1:0]    weights,
    input  logic                        enb,
    input  logic [REF_W-1:0]            refr_cfg,
    input  logic [LEAK_W-1:0]           leak_cfg,
    input  logic signed [V_WIDTH-1:0]   vth,
    output logic                        fire,
    output logic signed [V_WIDTH-1:0]   v
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] chunk_sum;
    logic [REF_W-1:0]        refr;
    logic                    refr_busy;
    int                      vth_i;
    int                      t_sat;
    int                      v_sub;

    always_comb begin
        chunk_sum = '0;
        for (int j = 0; j < CHUNK; j++) begin
            if (spikes[j]) begin
                chunk_sum = chunk_sum + ACC_W'($signed(weights[j*W_WIDTH +: W_WIDTH]));
            end
        end
    end

    // Fire arithmetic done in 32-bit signed space so intermediate sums never wrap.
    always_comb begin
        vth_i     = 32'(vth);
        t_sat     = sat_v(leak(32'(v) + 32'(acc), 32'(leak_cfg)), V_WIDTH);
        v_sub     = sat_v(t_sat - vth_i, V_WIDTH);
        refr_busy = (refr != '0);
        fire      = !enb && !refr_busy && (swp ? (t_sat <= vth_i) : (t_sat >= vth_i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v    <= '0;
            acc  <= '0;
            refr <= '0;
        end else if (clr_all) begin
            v    <= '0;
            acc  <= '0;
            refr <= '0;
        end else begin
            if (clr_state) begin
                v    <= '0;
                refr <= '0;
            end
            if (integrate) begin
                acc <= acc + chunk_sum;
            end
            if (fire_en) begin
                acc <= '0;
                if (enb) begin
                    v    <= '0;
                    refr <= '0;
                end else if (refr_busy) begin
                    refr <= refr - REF_W'(1);
                end else if (fire) begin
                    v    <= V_WIDTH'(rst_sub ? v_sub : 0);
                    refr <= refr_cfg;
                end else begin
                    v <= V_WIDTH'(t_sat);
                end
            end
        end
    end

endmodule

// File: rtl/cim_lif_array.sv
// rtl/cim_lif_array.sv - time-multiplexed CIM macro of LIF neurons with on-chip signed weights
// Ports: clk, rst_n (async low); pd (sync power-down); en/ft start a timestep, spike_in
// sampled with en; swp/rst_sub fire modes; ncfg per-neuron config; busy, req (result pulse),
// neuron_out (fire vector); we/re/wa/wc/wd weight access, rd read data, werr rejected access.
module cim_lif_array
    import cim_pkg::*;
#(
    parameter int N_NEURON = DEF_N_NEURON,
    parameter int N_INPUT  = DEF_N_INPUT,
    parameter int CHUNK    = DEF_CHUNK,
    parameter int W_WIDTH  = DEF_W_WIDTH,
    parameter int V_WIDTH  = DEF_V_WIDTH,
    parameter int LEAK_W   = DEF_LEAK_W,
    parameter int REF_W    = DEF_REF_W,
    localparam int K       = num_chunks(N_INPUT, CHUNK),
    localparam int CFG_W   = cfg_width(V_WIDTH, LEAK_W, REF_W),
    localparam int WA_W    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1,
    localparam int WC_W    = (K > 1) ? $clog2(K) : 1,
    localparam int ROW_W   = CHUNK * W_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pd,
    input  logic                        en,
    input  logic                        ft,
    input  logic                        swp,
    input  logic                        rst_sub,
    input  logic [N_INPUT-1:0]          spike_in,
    input  logic [N_NEURON*CFG_W-1:0]   ncfg,
    output logic                        busy,
    output logic                        req,
    output logic [N_NEURON-1:0]         neuron_out,
    input  logic                        we,
    input  logic                        re,
    input  logic [WA_W-1:0]             wa,
    input  logic [WC_W-1:0]             wc,
    input  logic [ROW_W-1:0]            wd,
    output logic [ROW_W-1:0]            rd,
    output logic                        werr
);

    localparam int ACC_W  = V_WIDTH + W_WIDTH + $clog2(N_INPUT);
    localparam int LEAK_B = leak_lsb(V_WIDTH);
    localparam int REFR_B = refr_lsb(V_WIDTH, LEAK_W);
    localparam int ENB_B  = enb_bit(V_WIDTH, LEAK_W, REF_W);

    state_t              state_q;
    state_t              state_d;
    logic [WC_W-1:0]     cnt_q;
    logic [N_INPUT-1:0]  spike_q;
    logic [CHUNK-1:0]    spike_chunk;
    logic [ROW_W-1:0]    wmem [N_NEURON][K];
    logic [N_NEURON-1:0] fire_vec;
    logic                start;
    logic                last_chunk;
    logic                in_int;
    logic                in_fire;
    logic                port_ok;
    logic                wc_ok;

    assign start       = (state_q == ST_IDLE) && en && !pd;
    assign last_chunk  = (cnt_q == WC_W'(K - 1));
    assign in_int      = (state_q == ST_INT);
    assign in_fire     = (state_q == ST_FIRE);
    assign port_ok     = (state_q == ST_IDLE) && !en;
    assign spike_chunk = spike_q[cnt_q*CHUNK +: CHUNK];

    // When K fills the column address space every wc is a valid chunk.
    generate
        if (K == (1 << WC_W)) begin : g_wc_full
            assign wc_ok = 1'b1;
        end else begin : g_wc_part
            assign wc_ok = (32'(wc) < K);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        req     = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: if (en) state_d = ST_INT;
            ST_INT:  if (last_chunk) state_d = ST_FIRE;
            ST_FIRE: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (pd) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            spike_q    <= '0;
            neuron_out <= '0;
        end else if (pd) begin
            cnt_q      <= '0;
            neuron_out <= '0;
        end else begin
            cnt_q <= in_int ? (cnt_q + WC_W'(1)) : '0;
            if (start) begin
                spike_q <= spike_in;
            end
            if (in_fire) begin
                neuron_out <= fire_vec;
            end
        end
    end

    // Weight storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (port_ok && we && wc_ok) begin
            wmem[wa][wc] <= wd;
        end
    end

    // A simultaneous write wins and leaves rd holding its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd   <= '0;
            werr <= 1'b0;
        end else begin
            werr <= (we || re) && !port_ok;
            if (port_ok && re && !we) begin
                rd <= wc_ok ? wmem[wa][wc] : '0;
            end
        end
    end

    for (genvar i = 0; i < N_NEURON; i++) begin : g_neuron
        logic [CFG_W-1:0] cfg;
        assign cfg = ncfg[i*CFG_W +: CFG_W];

        cim_lif_neuron #(
            .CHUNK   (CHUNK),
            .W_WIDTH (W_WIDTH),
            .V_WIDTH (V_WIDTH),
            .LEAK_W  (LEAK_W),
            .REF_W   (REF_W),
            .ACC_W   (ACC_W)
        ) u_neuron (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_all   (pd),
            .clr_state (start && ft),
            .integrate (in_int),
            .fire_en   (in_fire),
            .swp       (swp),
            .rst_sub   (rst_sub),
            .spikes    (spike_chunk),
            .weights   (wmem[i][cnt_q]),
            .enb       (cfg[ENB_B]),
            .refr_cfg  (cfg[REFR_B +: REF_W]),
            .leak_cfg  (cfg[LEAK_B +: LEAK_W]),
            .vth       ($signed(cfg[V_WIDTH-1:0])),
            .fire      (fire_vec[i]),
            .v         ()
        );
    end

endmodule
